// File: rtl/alu_exec.sv
// alu_exec: single-lane integer execution unit returning a registered RS writeback packet.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (MUL state, counter, drop_err).

`ifndef RS_WIDTH
`define RS_WIDTH   127
`define RS_DATA1   126:95
`define RS_DATA2   94:63
`define RS_IMM     62:31
`define RS_RD      30:25
`define RS_RDY1    24
`define RS_RDY2    23
`define RS_OPCODE  22:16
`define RS_FUNCT3  15:13
`define RS_CSIGS   12:6
`define RS_ROB     5:0
`endif

`ifndef ALU_WIDTH
`define ALU_WIDTH  39
`define ALU_READY  38
`define ALU_REG    37:32
`define ALU_RESULT 31:0
`endif

module alu_exec #(
    parameter int unsigned PREG_WIDTH = 6,
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [`RS_WIDTH-1:0]  in_entry,
    output logic [`ALU_WIDTH-1:0] wb_out,
    output logic [5:0]            wb_rob,
    output logic                  fu_free,
    output logic                  drop_err
);

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic [31:0]           w_a;
    logic [31:0]           w_b;
    logic [31:0]           w_imm;
    logic [31:0]           w_result;
    logic [6:0]            w_opcode;
    logic [6:0]            w_csigs;
    logic [2:0]            w_funct3;
    logic [PREG_WIDTH-1:0] w_rd;
    logic [5:0]            w_rob;
    logic                  w_issue;
    logic                  w_unused;
    logic [`ALU_WIDTH-1:0] r_wb;
    logic [5:0]            r_wb_rob;

    assign w_opcode = in_entry[`RS_OPCODE];
    assign w_funct3 = in_entry[`RS_FUNCT3];
    assign w_csigs  = in_entry[`RS_CSIGS];
    assign w_rd     = in_entry[`RS_RD];
    assign w_rob    = in_entry[`RS_ROB];
    assign w_imm    = in_entry[`RS_IMM];
    assign w_a      = in_entry[`RS_DATA1];
    assign w_b      = (w_opcode == OP_REG) ? in_entry[`RS_DATA2] : w_imm;

    // Operand-ready bits are guaranteed set by the RS at issue, so they are not consulted.
    assign w_unused = ^{in_entry[`RS_RDY1], in_entry[`RS_RDY2], w_csigs, 1'(MUL_CYCLES)};

    always_comb begin
        w_result = '0;
        if (w_opcode == OP_REG || w_opcode == OP_IMM) begin
            case (w_funct3)
                3'b000: w_result = w_csigs[6] ? (w_a - w_b) : (w_a + w_b);
                3'b001: w_result = w_a << w_b[4:0];
                3'b010: w_result = {31'b0, ($signed(w_a) < $signed(w_b))};
                3'b011: w_result = {31'b0, (w_a < w_b)};
                3'b100: w_result = w_a ^ w_b;
                3'b101: w_result = w_csigs[6] ? 32'($signed(w_a) >>> w_b[4:0]) : (w_a >> w_b[4:0]);
                3'b110: w_result = w_a | w_b;
                3'b111: w_result = w_a & w_b;
                default: w_result = '0;
            endcase
        end else if (w_opcode == OP_LUI) begin
            w_result = w_imm;
        end
    end

`ifdef ALU_MUL_EN
    // Each iteration consumes MUL_K multiplier bits so any MUL_CYCLES in 1..32 covers 32 bits.
    localparam int unsigned MUL_K = (32 + MUL_CYCLES - 1) / MUL_CYCLES;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [4:0]            r_cnt;
    logic [31:0]           r_mcand;
    logic [31:0]           r_mplier;
    logic [31:0]           r_acc;
    logic [31:0]           w_acc_step;
    logic [PREG_WIDTH-1:0] r_mul_rd;
    logic [5:0]            r_mul_rob;
    logic                  r_drop;
    logic                  w_is_mul;
    logic                  w_accept_mul;
    logic                  w_mul_done;

    assign w_is_mul     = (w_opcode == OP_REG) && (w_funct3 == 3'b000) && w_csigs[5];
    assign w_accept_mul = in_valid && (r_state == S_IDLE) && w_is_mul;
    assign w_issue      = in_valid && (r_state == S_IDLE) && !w_is_mul;
    assign w_mul_done   = (r_state == S_MUL) && (r_cnt == 5'(MUL_CYCLES - 1));
    assign drop_err     = r_drop;

    always_comb begin
        w_state_nxt = r_state;
        fu_free     = 1'b0;
        case (r_state)
            S_IDLE: begin
                fu_free = !(in_valid && w_is_mul);
                if (in_valid && w_is_mul) begin
                    w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                if (w_mul_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_acc_step = r_acc;
        for (int unsigned i = 0; i < MUL_K; i++) begin
            if (r_mplier[5'(i)]) begin
                w_acc_step = w_acc_step + (r_mcand << i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_mul_rd  <= '0;
            r_mul_rob <= '0;
            r_drop    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept_mul) begin
                r_cnt     <= '0;
                r_acc     <= '0;
                r_mcand   <= w_a;
                r_mplier  <= w_b;
                r_mul_rd  <= w_rd;
                r_mul_rob <= w_rob;
            end else if (r_state == S_MUL) begin
                r_cnt    <= w_mul_done ? 5'd0 : (r_cnt + 5'd1);
                r_acc    <= w_acc_step;
                r_mcand  <= r_mcand << MUL_K;
                r_mplier <= r_mplier >> MUL_K;
                if (in_valid) begin
                    r_drop <= 1'b1;
                end
            end
        end
    end
`else
    assign w_issue  = in_valid;
    assign fu_free  = 1'b1;
    assign drop_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb     <= '0;
            r_wb_rob <= '0;
        end else if (w_issue) begin
            r_wb[`ALU_READY]  <= 1'b1;
            r_wb[`ALU_REG]    <= w_rd;
            r_wb[`ALU_RESULT] <= w_result;
            r_wb_rob          <= w_rob;
        end
`ifdef ALU_MUL_EN
        else if (w_mul_done) begin
            r_wb[`ALU_READY]  <= 1'b1;
            r_wb[`ALU_REG]    <= r_mul_rd;
            r_wb[`ALU_RESULT] <= w_acc_step;
            r_wb_rob          <= r_mul_rob;
        end
`endif
        else begin
            r_wb[`ALU_READY] <= 1'b0;
        end
    end

    assign wb_out = r_wb;
    assign wb_rob = r_wb_rob;

endmodule

// File: tb/tb_alu_exec.sv
// Directed and randomized bench for alu_exec against an arithmetic reference model.
module tb_alu_exec;

    localparam int unsigned MC  = 32;
    localparam logic [6:0]  OPR = 7'b0110011;
    localparam logic [6:0]  OPI = 7'b0010011;
    localparam logic [6:0]  LUI = 7'b0110111;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         in_valid = 1'b0;
    logic [126:0] in_entry = '0;
    logic [38:0]  wb_out;
    logic [5:0]   wb_rob;
    logic         fu_free;
    logic         drop_err;

    int n_tests = 0;
    int n_fail  = 0;

    alu_exec #(.PREG_WIDTH(6), .MUL_CYCLES(MC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_entry (in_entry),
        .wb_out   (wb_out),
        .wb_rob   (wb_rob),
        .fu_free  (fu_free),
        .drop_err (drop_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [126:0] mk(input logic [31:0] d1, input logic [31:0] d2,
                                        input logic [31:0] imm, input logic [5:0] rd,
                                        input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] cs, input logic [5:0] rob);
        return {d1, d2, imm, rd, 1'b1, 1'b1, op, f3, cs, rob};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [31:0] d1, input logic [31:0] d2,
                                            input logic [31:0] imm, input logic [6:0] op,
                                            input logic [2:0] f3, input logic alt);
        longint unsigned ua, ub, p2;
        longint          sa, sb, q;
        int unsigned     sh;
        logic [31:0]     b;
        if (op == LUI) return imm;
        if (op != OPR && op != OPI) return 32'd0;
        b  = (op == OPR) ? d2 : imm;
        sh = b % 32;
        ua = longint'(d1);
        ub = longint'(b);
        sa = longint'(int'(d1));
        sb = longint'(int'(b));
        p2 = 64'd1 << sh;
        case (f3)
            3'd0: return alt ? 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000) : 32'((ua + ub) % 64'h1_0000_0000);
            3'd1: return 32'((ua * p2) % 64'h1_0000_0000);
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return (ua < ub) ? 32'd1 : 32'd0;
            3'd4: return d1 ^ b;
            3'd5: begin
                if (!alt) return 32'(ua / p2);
                q = sa / longint'(p2);
                if (sa < 0 && (sa % longint'(p2)) != 0) q = q - 1;
                return 32'(q);
            end
            3'd6: return d1 | b;
            default: return d1 & b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [126:0] e);
        in_valid = v;
        in_entry = e;
        @(negedge clk);
    endtask

    task automatic ck_wb(input string tag, input logic [5:0] rd, input logic [31:0] res, input logic [5:0] rob);
        chk({tag, ".ready"}, 64'(wb_out[38]), 64'd1);
        chk({tag, ".reg"}, 64'(wb_out[37:32]), 64'(rd));
        chk({tag, ".result"}, 64'(wb_out[31:0]), 64'(res));
        chk({tag, ".rob"}, 64'(wb_rob), 64'(rob));
    endtask

    initial begin
        logic [31:0] d1, d2, imm, exp_r;
        logic [6:0]  op, cs;
        logic [2:0]  f3;
        logic [5:0]  rd, rob;
        logic        v;
        int          pulses;

        #1;
        chk("rst.wb_out", 64'(wb_out), 64'd0);
        chk("rst.wb_rob", 64'(wb_rob), 64'd0);
        chk("rst.fu_free", 64'(fu_free), 64'd1);
        chk("rst.drop_err", 64'(drop_err), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, mk(32'd7, 32'd9, 32'd0, 6'd5, OPR, 3'd0, 7'h00, 6'd17));
        ck_wb("add", 6'd5, 32'd16, 6'd17);
        chk("add.fu_free", 64'(fu_free), 64'd1);
        drive(1'b0, '0);
        chk("add.pulse_end", 64'(wb_out[38]), 64'd0);

        drive(1'b1, mk(32'h8000_0000, 32'd0, 32'd4, 6'd3, OPI, 3'd5, 7'h40, 6'd2));
        ck_wb("srai", 6'd3, 32'hF800_0000, 6'd2);
        drive(1'b1, mk(32'h8000_0000, 32'd0, 32'd4, 6'd3, OPI, 3'd5, 7'h00, 6'd2));
        ck_wb("srli", 6'd3, 32'h0800_0000, 6'd2);
        drive(1'b1, mk(32'hFFFF_FFFF, 32'd1, 32'd0, 6'd4, OPR, 3'd2, 7'h00, 6'd3));
        ck_wb("slt", 6'd4, 32'd1, 6'd3);
        drive(1'b1, mk(32'hFFFF_FFFF, 32'd1, 32'd0, 6'd4, OPR, 3'd3, 7'h00, 6'd3));
        ck_wb("sltu", 6'd4, 32'd0, 6'd3);
        drive(1'b1, mk(32'hFFFF_FFFF, 32'd1, 32'd0, 6'd4, OPR, 3'd0, 7'h00, 6'd3));
        ck_wb("addwrap", 6'd4, 32'd0, 6'd3);
        drive(1'b0, '0);

        drive(1'b1, mk(32'd100, 32'd23, 32'd0, 6'd10, OPR, 3'd0, 7'h00, 6'd40));
        ck_wb("b2b0", 6'd10, 32'd123, 6'd40);
        chk("b2b0.fu_free", 64'(fu_free), 64'd1);
        drive(1'b1, mk(32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 6'd11, OPR, 3'd4, 7'h00, 6'd41));
        ck_wb("b2b1", 6'd11, 32'h0000_FF00, 6'd41);
        chk("b2b1.fu_free", 64'(fu_free), 64'd1);
        drive(1'b1, mk(32'd0, 32'd0, 32'h1234_5000, 6'd12, LUI, 3'd0, 7'h00, 6'd42));
        ck_wb("b2b2", 6'd12, 32'h1234_5000, 6'd42);
        chk("b2b2.fu_free", 64'(fu_free), 64'd1);
        drive(1'b0, '0);
        chk("b2b.pulse_end", 64'(wb_out[38]), 64'd0);

        for (int n = 0; n < 300; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            d1  = $urandom;
            d2  = $urandom;
            imm = $urandom;
            f3  = 3'($urandom);
            cs  = 7'($urandom);
            rd  = 6'($urandom);
            rob = 6'($urandom);
            case ($urandom_range(0, 3))
                0:       op = OPR;
                1:       op = OPI;
                2:       op = LUI;
                default: op = 7'($urandom);
            endcase
`ifdef ALU_MUL_EN
            cs[5] = 1'b0;
`endif
            exp_r = ref_alu(d1, d2, imm, op, f3, cs[6]);
            drive(v, mk(d1, d2, imm, rd, op, f3, cs, rob));
            if (v) begin
                ck_wb("rand", rd, exp_r, rob);
            end else begin
                chk("rand.idle", 64'(wb_out[38]), 64'd0);
            end
            chk("rand.fu_free", 64'(fu_free), 64'd1);
        end
        drive(1'b0, '0);

`ifdef ALU_MUL_EN
        in_valid = 1'b1;
        in_entry = mk(32'd6, 32'd7, 32'd0, 6'd9, OPR, 3'd0, 7'h20, 6'd33);
        #1;
        chk("mul.fu_free_issue", 64'(fu_free), 64'd0);
        @(negedge clk);
        for (int j = 0; j < int'(MC); j++) begin
            chk("mul.busy", 64'(fu_free), 64'd0);
            chk("mul.no_wb", 64'(wb_out[38]), 64'd0);
            if (j == 10) drive(1'b1, mk(32'd1, 32'd1, 32'd0, 6'd20, OPR, 3'd0, 7'h00, 6'd21));
            else         drive(1'b0, '0);
        end
        ck_wb("mul", 6'd9, 32'd42, 6'd33);
        chk("mul.fu_free_done", 64'(fu_free), 64'd1);
        chk("mul.drop_err", 64'(drop_err), 64'd1);
        drive(1'b1, mk(32'd2, 32'd3, 32'd0, 6'd14, OPR, 3'd0, 7'h00, 6'd15));
        ck_wb("mul.next", 6'd14, 32'd5, 6'd15);
        drive(1'b0, '0);

        for (int n = 0; n < 4; n++) begin
            int lat;
            logic got;
            d1  = $urandom;
            d2  = $urandom;
            rd  = 6'($urandom);
            rob = 6'($urandom);
            exp_r = 32'((longint'(d1) * longint'(d2)) % 64'h1_0000_0000);
            drive(1'b1, mk(d1, d2, 32'd0, rd, OPR, 3'd0, 7'h20, rob));
            lat = 0;
            got = 1'b0;
            for (int k = 0; k < int'(MC) + 4 && !got; k++) begin
                if (wb_out[38]) got = 1'b1;
                else begin
                    lat++;
                    drive(1'b0, '0);
                end
            end
            chk("rmul.seen", 64'(got), 64'd1);
            chk("rmul.latency", 64'(lat), 64'(MC));
            ck_wb("rmul", rd, exp_r, rob);
        end

        drive(1'b1, mk(32'd5, 32'd5, 32'd0, 6'd13, OPR, 3'd0, 7'h20, 6'd50));
        for (int k = 0; k < 5; k++) drive(1'b0, '0);
`else
        drive(1'b1, mk(32'd6, 32'd7, 32'd0, 6'd9, OPR, 3'd0, 7'h20, 6'd33));
        ck_wb("mulenc_as_add", 6'd9, 32'd13, 6'd33);
        chk("mulenc.fu_free", 64'(fu_free), 64'd1);
        chk("mulenc.drop_err", 64'(drop_err), 64'd0);
        drive(1'b1, mk(32'd6, 32'd7, 32'd0, 6'd9, OPR, 3'd0, 7'h60, 6'd34));
        ck_wb("mulenc_as_sub", 6'd9, 32'hFFFF_FFFF, 6'd34);
        drive(1'b1, mk(32'd1, 32'd2, 32'd0, 6'd7, OPR, 3'd6, 7'h00, 6'd9));
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.wb_out", 64'(wb_out), 64'd0);
        chk("midrst.wb_rob", 64'(wb_rob), 64'd0);
        chk("midrst.fu_free", 64'(fu_free), 64'd1);
        chk("midrst.drop_err", 64'(drop_err), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < int'(MC) + 4; k++) begin
            drive(1'b0, '0);
            if (wb_out[38]) pulses++;
        end
        chk("midrst.no_wb", 64'(pulses), 64'd0);
        chk("midrst.fu_free_after", 64'(fu_free), 64'd1);
        drive(1'b1, mk(32'd40, 32'd2, 32'd0, 6'd1, OPR, 3'd0, 7'h00, 6'd2));
        ck_wb("postrst", 6'd1, 32'd42, 6'd2);
        drive(1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
